// File: rtl/reg_file_sweep_pkg.sv
// Shared definitions for the reg_file_sweep register bank: default widths, FSM encoding and the
// all-zero word the clear sweep writes.
package reg_file_sweep_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;

  typedef enum logic {
    StClear = 1'b0,
    StIdle  = 1'b1
  } state_e;

  localparam logic [DATA_WIDTH_DEF-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/reg_file_clr_ctr.sv
// Clear-sweep pointer for reg_file_sweep: walks every address once and flags the last one.
module reg_file_clr_ctr
  import reg_file_sweep_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  output logic [ADDR_WIDTH-1:0] ptr_o,
  output logic                  done_o
);

  logic [ADDR_WIDTH-1:0] ptr_q;

  // Increment wraps modulo the depth, so the pointer is back at 0 once the sweep completes.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    ptr_o  = ptr_q;
    done_o = en_i && (ptr_q == {ADDR_WIDTH{1'b1}});
  end

endmodule

// File: rtl/reg_file_sweep.sv
// Register bank with one write port, two registered read ports, write-to-read bypass and a
// post-reset clear sweep. Define REG_FILE_ZERO_REG_EN to hard-wire address 0 to zero.
module reg_file_sweep
  import reg_file_sweep_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  input  logic                  READ,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  WR_ACK,
  output logic                  BUSY
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] Zero = DATA_WIDTH'(ZERO_WORD);

  state_e                state_q;
  logic                  busy_q;
  logic                  wr_ack_q;
  logic [DATA_WIDTH-1:0] data_r1_q;
  logic [DATA_WIDTH-1:0] data_r2_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  clr_done;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd1_val;
  logic [DATA_WIDTH-1:0] rd2_val;

  reg_file_clr_ctr #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clr_ctr (
    .clk_i (CLK),
    .clr_i (RST),
    .en_i  (state_q == StClear),
    .ptr_o (clr_ptr),
    .done_o(clr_done)
  );

  // Single storage write port shared by the clear sweep and the user write.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr;
    mem_wdata = Zero;
    if (!RST) begin
      if (state_q == StClear) begin
        mem_we = 1'b1;
      end else if (WRITE) begin
`ifdef REG_FILE_ZERO_REG_EN
        mem_we    = (ADDR_W != '0);
`else
        mem_we    = 1'b1;
`endif
        mem_waddr = ADDR_W;
        mem_wdata = DATA_W;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Each read port forwards the in-flight write independently.
  always_comb begin
    rd1_val = mem_q[ADDR_R1];
    rd2_val = mem_q[ADDR_R2];
    if (WRITE && (ADDR_R1 == ADDR_W)) rd1_val = DATA_W;
    if (WRITE && (ADDR_R2 == ADDR_W)) rd2_val = DATA_W;
`ifdef REG_FILE_ZERO_REG_EN
    if (ADDR_R1 == '0) rd1_val = Zero;
    if (ADDR_R2 == '0) rd2_val = Zero;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StClear;
      busy_q    <= 1'b1;
      wr_ack_q  <= 1'b0;
      data_r1_q <= Zero;
      data_r2_q <= Zero;
    end else begin
      wr_ack_q <= 1'b0;
      unique case (state_q)
        StClear: begin
          if (clr_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StIdle: begin
          wr_ack_q <= WRITE;
          if (READ) begin
            data_r1_q <= rd1_val;
            data_r2_q <= rd2_val;
          end
        end
      endcase
    end
  end

  assign DATA_R1 = data_r1_q;
  assign DATA_R2 = data_r2_q;
  assign WR_ACK  = wr_ack_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_reg_file_sweep.sv
// Self-checking bench for reg_file_sweep: an array-level reference model compared every cycle,
// plus directed literal checks. Honours REG_FILE_ZERO_REG_EN like the design.
module tb_reg_file_sweep;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] data_w;
  logic          read;
  logic [AW-1:0] addr_r1;
  logic [AW-1:0] addr_r2;
  logic [DW-1:0] data_r1;
  logic [DW-1:0] data_r2;
  logic          wr_ack;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  reg_file_sweep dut (
    .CLK    (clk),
    .RST    (rst),
    .WRITE  (write),
    .ADDR_W (addr_w),
    .DATA_W (data_w),
    .READ   (read),
    .ADDR_R1(addr_r1),
    .ADDR_R2(addr_r2),
    .DATA_R1(data_r1),
    .DATA_R2(data_r2),
    .WR_ACK (wr_ack),
    .BUSY   (busy)
  );

  always #5 clk = ~clk;

  // Reference model: the sweep is a countdown, and the whole array reads as zero once it ends.
  logic [DW-1:0] m_mem [DEPTH];
  int            clear_left;
  logic [DW-1:0] exp_r1, exp_r2;
  logic          exp_ack, exp_busy;

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
`ifdef REG_FILE_ZERO_REG_EN
    if (a == 0) return '0;
`endif
    if (write && a == addr_w) return data_w;
    return m_mem[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      clear_left <= DEPTH;
      exp_r1     <= '0;
      exp_r2     <= '0;
      exp_ack    <= 1'b0;
      exp_busy   <= 1'b1;
    end else if (clear_left > 0) begin
      clear_left <= clear_left - 1;
      exp_ack    <= 1'b0;
      if (clear_left == 1) begin
        exp_busy <= 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      end
    end else begin
      exp_ack <= write;
      if (read) begin
        exp_r1 <= model_rd(addr_r1);
        exp_r2 <= model_rd(addr_r2);
      end
`ifdef REG_FILE_ZERO_REG_EN
      if (write && addr_w != 0) m_mem[addr_w] <= data_w;
`else
      if (write) m_mem[addr_w] <= data_w;
`endif
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("model_r1", data_r1, exp_r1);
      check("model_r2", data_r2, exp_r2);
      check("model_ack", {31'b0, wr_ack}, {31'b0, exp_ack});
      check("model_busy", {31'b0, busy}, {31'b0, exp_busy});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_sweep(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(name, n, 32);
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0;
    addr_w = '0; addr_r1 = '0; addr_r2 = '0; data_w = '0;
    tick();
    checking = 1'b1;
    tick();
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_r1", data_r1, 32'h0);
    check("rst_ack", {31'b0, wr_ack}, 32'd0);
    rst = 1'b0;

    // Sweep length, with a write on the 10th sweep edge that must be ignored.
    begin
      int n = 0;
      while (busy && n < 100) begin
        write  = (n == 9);
        addr_w = 5'd2;
        data_w = 32'hFFFF_FFFF;
        tick();
        n++;
        if (n == 10) check("lock_ack", {31'b0, wr_ack}, 32'd0);
      end
      write = 1'b0;
      check("busy_len", n, 32);
    end

    read = 1'b1; addr_r1 = 5'd2; addr_r2 = 5'd31;
    tick();
    check("swept_r1", data_r1, 32'h0);
    check("swept_r2", data_r2, 32'h0);
    read = 1'b0;

    write = 1'b1; addr_w = 5'd5; data_w = 32'hDEAD_BEEF;
    tick();
    check("wr_ack", {31'b0, wr_ack}, 32'd1);
    write = 1'b0; read = 1'b1; addr_r1 = 5'd5; addr_r2 = 5'd5;
    tick();
    check("ack_pulse", {31'b0, wr_ack}, 32'd0);
    check("rd5_r1", data_r1, 32'hDEAD_BEEF);
    check("rd5_r2", data_r2, 32'hDEAD_BEEF);
    read = 1'b0;

    write = 1'b1; addr_w = 5'd3; data_w = 32'hA5A5_A5A5;
    tick();
    addr_w = 5'd7; data_w = 32'h1234_5678; read = 1'b1; addr_r1 = 5'd7; addr_r2 = 5'd3;
    tick();
    check("byp_r1", data_r1, 32'h1234_5678);
    check("byp_r2", data_r2, 32'hA5A5_A5A5);
    check("b2b_ack", {31'b0, wr_ack}, 32'd1);

    addr_w = 5'd9; data_w = 32'hCAFE_F00D; addr_r1 = 5'd9; addr_r2 = 5'd9;
    tick();
    check("byp2_r1", data_r1, 32'hCAFE_F00D);
    check("byp2_r2", data_r2, 32'hCAFE_F00D);

    read = 1'b0; data_w = 32'h1;
    tick();
    check("hold_r1", data_r1, 32'hCAFE_F00D);
    write = 1'b0; read = 1'b1;
    tick();
    check("rd9_r1", data_r1, 32'h1);
    read = 1'b0;

    for (int i = 0; i < 8; i++) begin
      write = 1'b1; addr_w = AW'(i * 4 + 2); data_w = 32'h1000_0000 + i * 32'h0101_0101;
      read = 1'b1; addr_r1 = AW'(i * 4 + 2); addr_r2 = AW'(((i + 7) % 8) * 4 + 2);
      tick();
    end
    write = 1'b0; read = 1'b0;

    write = 1'b1; addr_w = 5'd0; data_w = 32'h1;
    tick();
    check("z_ack", {31'b0, wr_ack}, 32'd1);
    write = 1'b0; read = 1'b1; addr_r1 = 5'd0; addr_r2 = 5'd0;
    tick();
`ifdef REG_FILE_ZERO_REG_EN
    check("z_rd", data_r1, 32'h0);
`else
    check("z_rd", data_r1, 32'h1);
`endif
    write = 1'b1; addr_w = 5'd0; data_w = 32'h2; addr_r1 = 5'd0; addr_r2 = 5'd5;
    tick();
`ifdef REG_FILE_ZERO_REG_EN
    check("z_byp", data_r1, 32'h0);
`else
    check("z_byp", data_r1, 32'h2);
`endif
    check("z_byp_r2", data_r2, 32'hDEAD_BEEF);
    write = 1'b0; read = 1'b0;

    // Reset from idle, then a reset pulse 20 cycles into the sweep.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_sweep("mid_len");

    read = 1'b1; addr_r1 = 5'd5; addr_r2 = 5'd9;
    tick();
    check("reswept_r1", data_r1, 32'h0);
    check("reswept_r2", data_r2, 32'h0);
    read = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sweep.md
Name: reg_file_sweep

Overview:
- Register bank that consumes the single-bit storage cells: DEPTH words of DATA_WIDTH bits, one write port and two registered read ports.
- Feeds the ALU operand stage downstream.
- After every reset it runs a self-clearing sweep FSM, zeroing one word per cycle, and reports BUSY until the sweep finishes.
- Same-cycle write-to-read bypass, so consumers never see stale data.

Parameters:
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 5, address bits
- DEPTH, 2**ADDR_WIDTH, words; derived, never overridden

Ports:
- CLK  in  1  clock; all state changes on posedge
- RST  in  1  synchronous, active-high reset
- WRITE  in  1  write request, sampled at posedge
- ADDR_W  in  ADDR_WIDTH  write address
- DATA_W  in  DATA_WIDTH  write data
- READ  in  1  read request, sampled at posedge
- ADDR_R1  in  ADDR_WIDTH  read port 1 address
- ADDR_R2  in  ADDR_WIDTH  read port 2 address
- DATA_R1  out  DATA_WIDTH  read port 1 data, registered
- DATA_R2  out  DATA_WIDTH  read port 2 data, registered
- WR_ACK  out  1  one-cycle pulse confirming an accepted write
- BUSY  out  1  high while the clear sweep runs

Behaviour:
- Interface decision: one clock, CLK; reset is synchronous and active-high, RST.
- Reset values (any posedge with RST=1): DATA_R1=0, DATA_R2=0, WR_ACK=0, BUSY=1, state=CLEAR, clear pointer=0. While RST is held, the pointer stays at 0.
- State CLEAR, each posedge with RST=0:
  - mem[ptr] <= 0; ptr <= ptr+1.
  - On the edge that clears ptr=DEPTH-1: ptr wraps to 0, state <= IDLE, BUSY <= 0.
  - BUSY is therefore high for exactly DEPTH cycles after RST deasserts.
- CLEAR ignores ports:
  - WRITE is ignored: no store, no WR_ACK.
  - READ is ignored: DATA_R1/R2 hold 0.
- RST asserted mid-sweep restarts the sweep from ptr 0.
- State IDLE, WRITE=1: mem[ADDR_W] <= DATA_W at posedge; WR_ACK=1 for the following cycle only. Back-to-back writes give back-to-back acks.
- State IDLE, READ=1: DATA_Rn <= mem[ADDR_Rn] at posedge. Data is valid the cycle after the request (latency 1).
- State IDLE, READ=0: DATA_R1/R2 hold their last values.
- Bypass: if WRITE=1, READ=1 and ADDR_Rn==ADDR_W in the same cycle, DATA_Rn <= DATA_W (new value). Each port is decided independently; both ports may bypass at once.
- Both read ports may use the same address; both return identical data.
- Addresses are full-range; no out-of-range case exists. No arithmetic beyond the ptr increment, which wraps modulo DEPTH.
- RST in IDLE: RAM contents are not cleared on that edge; they are cleared by the sweep that follows.

Optional Feature:
- Macro REG_FILE_ZERO_REG_EN.
- Defined:
  - Address 0 always reads 0.
  - Writes to address 0 are discarded but still acked (WR_ACK=1).
  - Bypass never forwards to address 0.
- Undefined: address 0 is an ordinary storage word.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults, state encoding constants (ST_CLEAR=1'b0, ST_IDLE=1'b1), zero-word constant.
- One sub-module: reg_file_clr_ctr.
  - Holds the ADDR_WIDTH clear pointer and the done flag.
  - Has a synchronous clear input and an enable input.
- The storage array and read/bypass muxing stay in reg_file_sweep.

Test Plan:
- Reset sweep: RST=1 for 2 cycles, then 0 -> BUSY=1 for exactly 32 cycles, then 0. A READ of any address afterwards returns 0x00000000.
- Write/read: WRITE addr 5 = 0xDEADBEEF -> WR_ACK pulses 1 cycle. Next cycle READ R1=5, R2=5 -> both ports 0xDEADBEEF one cycle later.
- Bypass: same cycle WRITE addr 7 = 0x12345678, READ R1=7, R2=3 (holding 0xA5A5A5A5) -> DATA_R1=0x12345678, DATA_R2=0xA5A5A5A5.
- Busy lockout: WRITE addr 2 = 0xFFFFFFFF during cycle 10 of the sweep -> no WR_ACK. After the sweep, addr 2 reads 0.
- Mid-sweep reset: RST pulsed at sweep cycle 20 -> BUSY stays high a further 32 cycles after the pulse ends.
- REG_FILE_ZERO_REG_EN: write addr 0 = 0x1 -> WR_ACK=1, read addr 0 -> 0x00000000, including the same-cycle bypass case.
